axi_lite_mem_slave: RTL and testbench

//  AXI4-Lite responder: word-organised register memory answering the bus bridge's master port (m1_axi_*).

---
 rtl/axi_lite_mem_slave_if.sv | 34 +++
 rtl/axi_lite_mem_slave.sv | 182 ++++++++++++++++++
 tb/tb_axi_lite_mem_slave.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between the bridge master port and the memory responder.
// Clock and reset are kept outside the interface as plain module ports.
interface axi_lite_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite word memory with independent single-outstanding write and read engines.
// Define AXI_MEM_ERR_RESP_EN to answer out-of-range byte addresses with SLVERR instead of wrapping.
module axi_lite_mem_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                s0_axi_aclk,
  input  logic                s0_axi_areset,
  axi_lite_mem_slave_if.slave s0_axi
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned IDX_LO    = $clog2(STRB_W);
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned MEM_BYTES = DEPTH * STRB_W;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t              w_state;
  r_state_t              r_state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      w_idx;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  logic                  aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] aw_word, ar_word;
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic                  aw_err, ar_err;

  logic                  commit, c_err;
  logic [IDX_W-1:0]      c_idx;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;

  assign aw_hs = s0_axi.awvalid & s0_axi.awready;
  assign w_hs  = s0_axi.wvalid  & s0_axi.wready;
  assign ar_hs = s0_axi.arvalid & s0_axi.arready;

  assign aw_word = s0_axi.awaddr >> IDX_LO;
  assign ar_word = s0_axi.araddr >> IDX_LO;
  assign aw_idx  = aw_word[IDX_W-1:0];
  assign ar_idx  = ar_word[IDX_W-1:0];

`ifdef AXI_MEM_ERR_RESP_EN
  assign aw_err = 32'(s0_axi.awaddr) >= MEM_BYTES;
  assign ar_err = 32'(s0_axi.araddr) >= MEM_BYTES;
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // Word bits above the index are deliberately discarded (wrap or range-checked above).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_word, ar_word};

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int unsigned b = 0; b < STRB_W; b++)
      if (strb[b]) r[8*b +: 8] = new_word[8*b +: 8];
    return r;
  endfunction

  // Final handshake of a write: pick address from the bus or the latch, data likewise.
  always_comb begin
    commit = 1'b0;
    c_idx  = w_idx;
    c_err  = w_err;
    c_data = w_data;
    c_strb = w_strb;
    case (w_state)
      W_IDLE: if (aw_hs && w_hs) begin
        commit = 1'b1;
        c_idx  = aw_idx;
        c_err  = aw_err;
        c_data = s0_axi.wdata;
        c_strb = s0_axi.wstrb;
      end
      W_WAIT_DATA: if (w_hs) begin
        commit = 1'b1;
        c_data = s0_axi.wdata;
        c_strb = s0_axi.wstrb;
      end
      W_WAIT_ADDR: if (aw_hs) begin
        commit = 1'b1;
        c_idx  = aw_idx;
        c_err  = aw_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      w_state        <= W_IDLE;
      s0_axi.awready <= 1'b0;
      s0_axi.wready  <= 1'b0;
      s0_axi.bvalid  <= 1'b0;
      s0_axi.bresp   <= 2'b00;
      w_idx          <= '0;
      w_err          <= 1'b0;
      w_data         <= '0;
      w_strb         <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (commit && !c_err) mem[c_idx] <= merge_lanes(mem[c_idx], c_data, c_strb);
      if (commit) begin
        w_state        <= W_RESP;
        s0_axi.awready <= 1'b0;
        s0_axi.wready  <= 1'b0;
        s0_axi.bvalid  <= 1'b1;
        s0_axi.bresp   <= c_err ? 2'b10 : 2'b00;
      end else begin
        case (w_state)
          W_IDLE: begin
            s0_axi.awready <= 1'b1;
            s0_axi.wready  <= 1'b1;
            if (aw_hs) begin
              w_idx          <= aw_idx;
              w_err          <= aw_err;
              w_state        <= W_WAIT_DATA;
              s0_axi.awready <= 1'b0;
            end else if (w_hs) begin
              w_data         <= s0_axi.wdata;
              w_strb         <= s0_axi.wstrb;
              w_state        <= W_WAIT_ADDR;
              s0_axi.wready  <= 1'b0;
            end
          end
          W_RESP: if (s0_axi.bready) begin
            w_state        <= W_IDLE;
            s0_axi.bvalid  <= 1'b0;
            s0_axi.bresp   <= 2'b00;
            s0_axi.awready <= 1'b1;
            s0_axi.wready  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // mem is sampled before this edge's write lands, so a same-edge read sees old data.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      r_state        <= R_IDLE;
      s0_axi.arready <= 1'b0;
      s0_axi.rvalid  <= 1'b0;
      s0_axi.rdata   <= '0;
      s0_axi.rresp   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          s0_axi.arready <= 1'b1;
          if (ar_hs) begin
            r_state        <= R_DATA;
            s0_axi.arready <= 1'b0;
            s0_axi.rvalid  <= 1'b1;
            s0_axi.rdata   <= ar_err ? '0 : mem[ar_idx];
            s0_axi.rresp   <= ar_err ? 2'b10 : 2'b00;
          end
        end
        R_DATA: if (s0_axi.rready) begin
          r_state        <= R_IDLE;
          s0_axi.rvalid  <= 1'b0;
          s0_axi.arready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave: directed cases then randomized traffic against a word-array model.
// Builds with or without AXI_MEM_ERR_RESP_EN; the model follows the same macro.
module tb_axi_lite_mem_slave;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int BYTES = DW / 8;
`ifdef AXI_MEM_ERR_RESP_EN
  localparam int ADDR_LIMIT = DEPTH * BYTES;
`else
  localparam int ADDR_LIMIT = 1 << AW;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0]  model_mem [DEPTH];
  logic [1:0]     bq [$];
  logic [DW+1:0]  rq [$];

  axi_lite_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .s0_axi_aclk   (clk),
    .s0_axi_areset (rst),
    .s0_axi        (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic bit model_oor(input logic [AW-1:0] a);
    return int'(a) >= ADDR_LIMIT;
  endfunction

  function automatic int model_idx(input logic [AW-1:0] a);
    return (int'(a) / BYTES) % DEPTH;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [BYTES-1:0] st);
    int i;
    if (model_oor(a)) return;
    i = model_idx(a);
    for (int b = 0; b < BYTES; b++)
      if (st[b]) model_mem[i][8*b +: 8] = d[8*b +: 8];
  endfunction

  // Monitor: every B/R handshake is matched against the oldest pending expectation.
  initial begin
    logic [1:0]    eb;
    logic [DW+1:0] er;
    forever begin
      @(negedge clk);
      if (!rst && bus.bvalid && bus.bready) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else begin
          eb = bq.pop_front();
          check("bresp", 64'(bus.bresp), 64'(eb));
        end
      end
      if (!rst && bus.rvalid && bus.rready) begin
        if (rq.size() == 0) check("r_unexpected", 1, 0);
        else begin
          er = rq.pop_front();
          check("rdata", 64'(bus.rdata), 64'(er[DW-1:0]));
          check("rresp", 64'(bus.rresp), 64'(er[DW+1:DW]));
        end
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BYTES-1:0] st,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done, w_done, aw_hs, w_hs, done;
    int cyc;
    logic [1:0] er;
    er = model_oor(a) ? 2'b10 : 2'b00;
    model_write(a, d, st);
    bq.push_back(er);
    aw_done = 0; w_done = 0; cyc = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = st;
    bus.bready = (b_dly == 0);
    while (!(aw_done && w_done)) begin
      if (!aw_done) bus.awvalid = (cyc >= aw_dly);
      if (!w_done)  bus.wvalid  = (cyc >= w_dly);
      @(negedge clk);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1; bus.wvalid  = 1'b0; end
      cyc++;
      if (cyc > aw_dly + w_dly + 60) begin
        check("write_accept_timeout", 0, 1);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bq.delete(bq.size() - 1);
        return;
      end
    end
    cyc = 0;
    forever begin
      @(negedge clk);
      if (cyc == 0) check("b_latency", 64'(bus.bvalid), 1);
      if (cyc < b_dly) begin
        check("bvalid_hold", 64'(bus.bvalid), 1);
        check("bresp_hold", 64'(bus.bresp), 64'(er));
      end
      done = bus.bvalid && bus.bready;
      @(posedge clk); #1;
      if (done) break;
      cyc++;
      if (cyc == b_dly) bus.bready = 1'b1;
      if (cyc > b_dly + 60) begin check("b_timeout", 0, 1); break; end
    end
    bus.bready = 1'b1;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int r_dly, input bit use_exp,
                         input logic [DW-1:0] exp_d);
    bit hs, done;
    int cyc;
    logic [DW-1:0] ed;
    logic [1:0]    er;
    er = model_oor(a) ? 2'b10 : 2'b00;
    ed = model_oor(a) ? '0 : (use_exp ? exp_d : model_mem[model_idx(a)]);
    rq.push_back({er, ed});
    bus.araddr = a; bus.arvalid = 1'b1;
    bus.rready = (r_dly == 0);
    cyc = 0;
    forever begin
      @(negedge clk);
      hs = bus.arvalid && bus.arready;
      @(posedge clk); #1;
      if (hs) break;
      cyc++;
      if (cyc > 60) begin
        check("ar_timeout", 0, 1);
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        rq.delete(rq.size() - 1);
        return;
      end
    end
    bus.arvalid = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (cyc == 0) check("r_latency", 64'(bus.rvalid), 1);
      if (cyc < r_dly) begin
        check("rvalid_hold", 64'(bus.rvalid), 1);
        check("rdata_hold", 64'(bus.rdata), 64'(ed));
      end
      done = bus.rvalid && bus.rready;
      @(posedge clk); #1;
      if (done) break;
      cyc++;
      if (cyc == r_dly) bus.rready = 1'b1;
      if (cyc > r_dly + 60) begin check("r_timeout", 0, 1); break; end
    end
    bus.rready = 1'b1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, ADDR_LIMIT > 64 ? 63 : ADDR_LIMIT - 1))
                                       : AW'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [DW-1:0]    prior, d;
    logic [AW-1:0]    wa, ra;
    logic [BYTES-1:0] st;
    int ad, wd, bd, rd;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    rst = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 64'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                              bus.bresp, bus.rresp}), 0);
    check("rst_rdata", 64'(bus.rdata), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_readies", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);
    @(posedge clk); #1;

    do_read(8'h00, 0, 0, '0);
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(8'h04, 0, 0, '0);
    do_write(8'h04, 32'h11223344, 4'b0101, 3, 0, 5);
    do_read(8'h04, 3, 0, '0);
    check("partial_model", 64'(model_mem[1]), 64'hDE22BE44);
    do_write(8'h0B, 32'h55AA55AA, 4'h0, 0, 2, 0);
    do_read(8'h09, 0, 0, '0);

    do_write(8'h08, 32'h12345678, 4'hF, 0, 0, 0);
    prior = model_mem[2];
    fork
      do_write(8'h08, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      do_read(8'h08, 0, 1, prior);
    join
    do_read(8'h08, 0, 0, '0);

    do_write(8'h40, 32'hA5A55A5A, 4'hF, 0, 0, 0);
    do_read(8'h40, 0, 0, '0);
    do_read(8'h00, 0, 0, '0);

    for (int n = 0; n < 60; n++) begin
      wa = rand_addr(); ra = rand_addr();
      d = $urandom; st = BYTES'($urandom_range(0, 15));
      ad = $urandom_range(0, 3); wd = $urandom_range(0, 3);
      bd = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1 && model_idx(wa) != model_idx(ra)) begin
        fork
          do_write(wa, d, st, ad, wd, bd);
          do_read(ra, rd, 0, '0);
        join
      end else begin
        do_write(wa, d, st, ad, wd, bd);
        do_read(ra, rd, 0, '0);
      end
    end

    // Park both engines in their response states, then reset over them.
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 8'h0C; bus.wdata = 32'h0BADCAFE; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 8'h0C; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_bvalid", 64'(bus.bvalid), 1);
    check("pre_rst_rvalid", 64'(bus.rvalid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_bvalid", 64'(bus.bvalid), 0);
    check("rst_rvalid", 64'(bus.rvalid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    bq.delete(); rq.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_readies", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);
    @(posedge clk); #1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    do_read(8'h0C, 0, 0, '0);
    do_read(8'h08, 0, 0, '0);

    repeat (3) @(posedge clk);
    check("bq_drained", 64'(bq.size()), 0);
    check("rq_drained", 64'(rq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
